// File: rtl/stk_eng_ctrl.sv
// stk_eng_ctrl: per-engine LIFO stacks built as linked lists over one shared
// entry pool. A free list threads through the same next-pointer array, and an
// INV command drains one engine back to the free list an entry per cycle.
module stk_eng_ctrl #(
    parameter  int ENGS_N  = 4,
    parameter  int N       = 16,
    parameter  int W       = 128,
    localparam int PTR_W   = $clog2(N),
    localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cmd_vld,
    output logic               o_cmd_rdy,
    input  logic [ENGID_W-1:0] i_cmd_engid,
    input  logic [1:0]         i_cmd_opcode,
    input  logic [W-1:0]       i_cmd_dat,
    output logic               o_rsp_vld,
    output logic [ENGID_W-1:0] o_rsp_engid,
    output logic [1:0]         o_rsp_opcode,
    output logic [W-1:0]       o_rsp_dat,
    output logic               o_rsp_err,
    output logic [ENGS_N-1:0]  o_empty,
    output logic [CNT_W-1:0]   o_free_cnt,
    output logic               o_busy
);

    localparam logic [1:0]         OP_NOP  = 2'd0;
    localparam logic [1:0]         OP_PUSH = 2'd1;
    localparam logic [1:0]         OP_POP  = 2'd2;
    localparam logic [1:0]         OP_INV  = 2'd3;
    localparam logic [ENGID_W:0]   ENGS_L  = (ENGID_W+1)'(ENGS_N);
    localparam logic [PTR_W-1:0]   LAST_IX = PTR_W'(N - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(N);

    typedef enum logic [1:0] {INIT, IDLE, INV} state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [PTR_W-1:0]    r_initCnt;
    logic [W-1:0]        r_data [N];
    logic [PTR_W-1:0]    r_next [N];
    logic [PTR_W-1:0]    r_head [ENGS_N];
    logic [CNT_W-1:0]    r_cnt  [ENGS_N];
    logic [PTR_W-1:0]    r_freeHead;
    logic [CNT_W-1:0]    r_freeCnt;
    logic [ENGID_W-1:0]  r_invEng;
    logic                r_cmdRdy;
    logic                r_rspVld;
    logic [ENGID_W-1:0]  r_rspEng;
    logic [1:0]          r_rspOp;
    logic [W-1:0]        r_rspDat;
    logic                r_rspErr;
    logic [ENGS_N-1:0]   r_empty;

    logic                w_engValid;
    logic [ENGID_W-1:0]  w_engIdx;
    logic                w_doPush;
    logic                w_doPop;
    logic                w_doInvStart;
    logic                w_doInvStep;
    logic                w_rdyNext;
    logic                w_rspVldNext;
    logic [ENGID_W-1:0]  w_rspEngNext;
    logic [1:0]          w_rspOpNext;
    logic [W-1:0]        w_rspDatNext;
    logic                w_rspErrNext;
    logic [PTR_W-1:0]    w_popHead;
    logic [PTR_W-1:0]    w_invHead;

    assign w_engValid = ({1'b0, i_cmd_engid} < ENGS_L);
    assign w_engIdx   = w_engValid ? i_cmd_engid : '0;
    assign w_popHead  = r_head[w_engIdx];
    assign w_invHead  = r_head[r_invEng];

    assign o_cmd_rdy    = r_cmdRdy;
    assign o_rsp_vld    = r_rspVld;
    assign o_rsp_engid  = r_rspEng;
    assign o_rsp_opcode = r_rspOp;
    assign o_rsp_dat    = r_rspDat;
    assign o_rsp_err    = r_rspErr;
    assign o_empty      = r_empty;
    assign o_free_cnt   = r_freeCnt;
    assign o_busy       = (r_state != IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= INIT;
        else     r_state <= w_stateNext;
    end

    // Next state, command decode into datapath strobes, and next response
    always_comb begin
        w_stateNext  = r_state;
        w_doPush     = 1'b0;
        w_doPop      = 1'b0;
        w_doInvStart = 1'b0;
        w_doInvStep  = 1'b0;
        w_rdyNext    = 1'b0;
        w_rspVldNext = 1'b0;
        w_rspEngNext = '0;
        w_rspOpNext  = '0;
        w_rspDatNext = '0;
        w_rspErrNext = 1'b0;
        case (r_state)
            INIT: begin
                if (r_initCnt == LAST_IX) begin
                    w_stateNext = IDLE;
                    w_rdyNext   = 1'b1;
                end
            end
            IDLE: begin
                w_rdyNext = 1'b1;
                if (i_cmd_vld && r_cmdRdy && (i_cmd_opcode != OP_NOP)) begin
                    w_rspVldNext = 1'b1;
                    w_rspEngNext = i_cmd_engid;
                    w_rspOpNext  = i_cmd_opcode;
                    if (!w_engValid) begin
                        w_rspErrNext = 1'b1;
                    end else begin
                        case (i_cmd_opcode)
                            OP_PUSH: begin
                                if (r_freeCnt == '0) w_rspErrNext = 1'b1;
                                else                 w_doPush     = 1'b1;
                            end
                            OP_POP: begin
                                if (r_cnt[w_engIdx] == '0) begin
                                    w_rspErrNext = 1'b1;
                                end else begin
                                    w_doPop      = 1'b1;
                                    w_rspDatNext = r_data[w_popHead];
                                end
                            end
                            default: begin
                                if (r_cnt[w_engIdx] != '0) begin
                                    w_doInvStart = 1'b1;
                                    w_rspVldNext = 1'b0;
                                    w_rspEngNext = '0;
                                    w_rspOpNext  = '0;
                                    w_stateNext  = INV;
                                    w_rdyNext    = 1'b0;
                                end
                            end
                        endcase
                    end
                end
            end
            INV: begin
                w_doInvStep = 1'b1;
                if (r_cnt[r_invEng] == CNT_W'(1)) begin
                    w_stateNext  = IDLE;
                    w_rdyNext    = 1'b1;
                    w_rspVldNext = 1'b1;
                    w_rspEngNext = r_invEng;
                    w_rspOpNext  = OP_INV;
                end
            end
            default: w_stateNext = INIT;
        endcase
    end

    // Pointer, counter, ready and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_initCnt  <= '0;
            r_cmdRdy   <= 1'b0;
            r_rspVld   <= 1'b0;
            r_rspEng   <= '0;
            r_rspOp    <= '0;
            r_rspDat   <= '0;
            r_rspErr   <= 1'b0;
            r_empty    <= '1;
            r_freeHead <= '0;
            r_freeCnt  <= '0;
            r_invEng   <= '0;
            for (int e = 0; e < ENGS_N; e++) begin
                r_cnt[e]  <= '0;
                r_head[e] <= '0;
            end
        end else begin
            r_cmdRdy <= w_rdyNext;
            r_rspVld <= w_rspVldNext;
            r_rspEng <= w_rspEngNext;
            r_rspOp  <= w_rspOpNext;
            r_rspDat <= w_rspDatNext;
            r_rspErr <= w_rspErrNext;
            if (r_state == INIT) begin
                r_initCnt <= r_initCnt + 1'b1;
                if (r_initCnt == LAST_IX) begin
                    r_freeHead <= '0;
                    r_freeCnt  <= FULL_CNT;
                end
            end
            if (w_doPush) begin
                r_head[w_engIdx]  <= r_freeHead;
                r_freeHead        <= r_next[r_freeHead];
                r_cnt[w_engIdx]   <= r_cnt[w_engIdx] + 1'b1;
                r_freeCnt         <= r_freeCnt - 1'b1;
                r_empty[w_engIdx] <= 1'b0;
            end
            if (w_doPop) begin
                r_head[w_engIdx]  <= r_next[w_popHead];
                r_freeHead        <= w_popHead;
                r_cnt[w_engIdx]   <= r_cnt[w_engIdx] - 1'b1;
                r_freeCnt         <= r_freeCnt + 1'b1;
                r_empty[w_engIdx] <= (r_cnt[w_engIdx] == CNT_W'(1));
            end
            if (w_doInvStart) begin
                r_invEng <= w_engIdx;
            end
            if (w_doInvStep) begin
                r_head[r_invEng]  <= r_next[w_invHead];
                r_freeHead        <= w_invHead;
                r_cnt[r_invEng]   <= r_cnt[r_invEng] - 1'b1;
                r_freeCnt         <= r_freeCnt + 1'b1;
                r_empty[r_invEng] <= (r_cnt[r_invEng] == CNT_W'(1));
            end
        end
    end

    // Entry storage and link array; INIT rebuilds the free chain 0->1->..->N-1->0
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == INIT) begin
                r_next[r_initCnt] <= r_initCnt + 1'b1;
            end
            if (w_doPush) begin
                r_data[r_freeHead] <= i_cmd_dat;
                r_next[r_freeHead] <= r_head[w_engIdx];
            end
            if (w_doPop) begin
                r_next[w_popHead] <= r_freeHead;
            end
            if (w_doInvStep) begin
                r_next[w_invHead] <= r_freeHead;
            end
        end
    end

endmodule

// File: tb/tb_stk_eng_ctrl.sv
// tb_stk_eng_ctrl: directed bench for stk_eng_ctrl with default parameters
// (4 engines, 16-entry pool, 128-bit data); expected values are hand-derived.
module tb_stk_eng_ctrl;

    localparam int ENGS_N  = 4;
    localparam int N       = 16;
    localparam int W       = 128;
    localparam int ENGID_W = 2;
    localparam int CNT_W   = 5;

    logic               clk;
    logic               rst;
    logic               cmdVld;
    logic               cmdRdy;
    logic [ENGID_W-1:0] cmdEngId;
    logic [1:0]         cmdOpcode;
    logic [W-1:0]       cmdDat;
    logic               rspVld;
    logic [ENGID_W-1:0] rspEngId;
    logic [1:0]         rspOpcode;
    logic [W-1:0]       rspDat;
    logic               rspErr;
    logic [ENGS_N-1:0]  empty;
    logic [CNT_W-1:0]   freeCnt;
    logic               busy;

    int nChecks = 0;
    int nErrors = 0;

    stk_eng_ctrl #(.ENGS_N(ENGS_N), .N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_vld   (cmdVld),
        .o_cmd_rdy   (cmdRdy),
        .i_cmd_engid (cmdEngId),
        .i_cmd_opcode(cmdOpcode),
        .i_cmd_dat   (cmdDat),
        .o_rsp_vld   (rspVld),
        .o_rsp_engid (rspEngId),
        .o_rsp_opcode(rspOpcode),
        .o_rsp_dat   (rspDat),
        .o_rsp_err   (rspErr),
        .o_empty     (empty),
        .o_free_cnt  (freeCnt),
        .o_busy      (busy)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of command inputs, then step to 1 unit after the edge
    task automatic applyStimulus(input logic vld, input logic [ENGID_W-1:0] eng,
                                 input logic [1:0] op, input logic [W-1:0] dat);
        cmdVld    = vld;
        cmdEngId  = eng;
        cmdOpcode = op;
        cmdDat    = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 2'd0, '0);
    endtask

    task automatic checkRsp(input string tag, input logic [ENGID_W-1:0] eng,
                            input logic [1:0] op, input logic err, input logic [W-1:0] dat);
        checkOutput({tag, ".vld"}, W'(rspVld), W'(1));
        checkOutput({tag, ".eng"}, W'(rspEngId), W'(eng));
        checkOutput({tag, ".op"},  W'(rspOpcode), W'(op));
        checkOutput({tag, ".err"}, W'(rspErr), W'(err));
        checkOutput({tag, ".dat"}, rspDat, dat);
    endtask

    // Call with rst already low in the current cycle: 16 not-ready cycles then ready
    task automatic runInit(input string tag);
        for (int i = 0; i < N; i++) begin
            checkOutput({tag, ".rdyLow"}, W'(cmdRdy), W'(0));
            checkOutput({tag, ".noRsp"},  W'(rspVld), W'(0));
            idle();
        end
        checkOutput({tag, ".rdyHigh"}, W'(cmdRdy), W'(1));
        checkOutput({tag, ".free"},    W'(freeCnt), W'(16));
        checkOutput({tag, ".empty"},   W'(empty), W'(4'hF));
        checkOutput({tag, ".busy"},    W'(busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] d;
        rst = 1'b1;
        cmdVld = 1'b0; cmdEngId = '0; cmdOpcode = '0; cmdDat = '0;
        @(posedge clk); #1;
        idle();

        $display("[TB] reset state");
        checkOutput("rst.rdy",   W'(cmdRdy), W'(0));
        checkOutput("rst.vld",   W'(rspVld), W'(0));
        checkOutput("rst.dat",   rspDat, W'(0));
        checkOutput("rst.empty", W'(empty), W'(4'hF));
        checkOutput("rst.free",  W'(freeCnt), W'(0));
        checkOutput("rst.busy",  W'(busy), W'(1));

        rst = 1'b0;
        runInit("init0");

        $display("[TB] push/pop LIFO on e0");
        applyStimulus(1'b1, 2'd0, 2'd1, W'(32'hA));
        checkRsp("push0A", 2'd0, 2'd1, 1'b0, W'(0));
        checkOutput("push0A.free",  W'(freeCnt), W'(15));
        checkOutput("push0A.empty", W'(empty), W'(4'hE));
        applyStimulus(1'b1, 2'd0, 2'd1, W'(32'hB));
        checkRsp("push0B", 2'd0, 2'd1, 1'b0, W'(0));
        applyStimulus(1'b1, 2'd0, 2'd2, W'(0));
        checkRsp("pop0B", 2'd0, 2'd2, 1'b0, W'(32'hB));
        applyStimulus(1'b1, 2'd0, 2'd2, W'(0));
        checkRsp("pop0A", 2'd0, 2'd2, 1'b0, W'(32'hA));
        checkOutput("pop0A.free",  W'(freeCnt), W'(16));
        checkOutput("pop0A.empty", W'(empty), W'(4'hF));

        $display("[TB] NOP and pop on empty e3");
        applyStimulus(1'b1, 2'd1, 2'd0, W'(32'h55));
        checkOutput("nop.vld", W'(rspVld), W'(0));
        checkOutput("nop.dat", rspDat, W'(0));
        applyStimulus(1'b1, 2'd3, 2'd2, W'(0));
        checkRsp("popEmpty3", 2'd3, 2'd2, 1'b1, W'(0));
        checkOutput("popEmpty3.free",  W'(freeCnt), W'(16));
        checkOutput("popEmpty3.empty", W'(empty), W'(4'hF));
        idle();
        checkOutput("idle.vld", W'(rspVld), W'(0));

        $display("[TB] fill pool over e0..e3, overflow on 17th push");
        for (int i = 0; i < 17; i++) begin
            d = W'(32'h100 + i);
            applyStimulus(1'b1, 2'(i % 4), 2'd1, d);
            checkRsp("fillPush", 2'(i % 4), 2'd1, (i == 16), W'(0));
        end
        checkOutput("fill.free",  W'(freeCnt), W'(0));
        checkOutput("fill.empty", W'(empty), W'(4'h0));
        applyStimulus(1'b1, 2'd2, 2'd2, W'(0));
        checkRsp("fillPop2", 2'd2, 2'd2, 1'b0, W'(32'h10E));
        checkOutput("fillPop2.free", W'(freeCnt), W'(1));
        applyStimulus(1'b1, 2'd0, 2'd2, W'(0));
        checkRsp("fillPop0", 2'd0, 2'd2, 1'b0, W'(32'h10C));

        rst = 1'b1;
        idle();
        checkOutput("rst2.free",  W'(freeCnt), W'(0));
        checkOutput("rst2.empty", W'(empty), W'(4'hF));
        checkOutput("rst2.rdy",   W'(cmdRdy), W'(0));
        rst = 1'b0;
        runInit("init1");

        $display("[TB] INV of e1 holding five entries");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd1, 2'd1, W'(32'h200 + i));
            checkRsp("invFill", 2'd1, 2'd1, 1'b0, W'(0));
        end
        checkOutput("invFill.free", W'(freeCnt), W'(11));
        applyStimulus(1'b1, 2'd1, 2'd3, W'(0));
        for (int k = 1; k <= 5; k++) begin
            checkOutput("inv.rdyLow", W'(cmdRdy), W'(0));
            checkOutput("inv.noRsp",  W'(rspVld), W'(0));
            checkOutput("inv.busy",   W'(busy), W'(1));
            checkOutput("inv.free",   W'(freeCnt), W'(11 + k - 1));
            idle();
        end
        checkRsp("invDone", 2'd1, 2'd3, 1'b0, W'(0));
        checkOutput("invDone.rdy",   W'(cmdRdy), W'(1));
        checkOutput("invDone.free",  W'(freeCnt), W'(16));
        checkOutput("invDone.empty", W'(empty), W'(4'hF));
        applyStimulus(1'b1, 2'd1, 2'd3, W'(0));
        checkRsp("invEmpty", 2'd1, 2'd3, 1'b0, W'(0));
        checkOutput("invEmpty.rdy", W'(cmdRdy), W'(1));
        applyStimulus(1'b1, 2'd1, 2'd1, W'(32'h300));
        applyStimulus(1'b1, 2'd1, 2'd2, W'(0));
        checkRsp("postInvPop", 2'd1, 2'd2, 1'b0, W'(32'h300));

        $display("[TB] reset in the middle of INV");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd1, 2'd1, W'(32'h400 + i));
        end
        applyStimulus(1'b1, 2'd1, 2'd3, W'(0));
        idle();
        rst = 1'b1;
        idle();
        checkOutput("invRst.vld",   W'(rspVld), W'(0));
        checkOutput("invRst.rdy",   W'(cmdRdy), W'(0));
        checkOutput("invRst.busy",  W'(busy), W'(1));
        checkOutput("invRst.free",  W'(freeCnt), W'(0));
        checkOutput("invRst.empty", W'(empty), W'(4'hF));
        rst = 1'b0;
        runInit("init2");
        applyStimulus(1'b1, 2'd1, 2'd2, W'(0));
        checkRsp("invRstPop1", 2'd1, 2'd2, 1'b1, W'(0));
        checkOutput("invRstPop1.free", W'(freeCnt), W'(16));
        applyStimulus(1'b1, 2'd2, 2'd1, W'(32'h500));
        applyStimulus(1'b1, 2'd2, 2'd2, W'(0));
        checkRsp("invRstPop2", 2'd2, 2'd2, 1'b0, W'(32'h500));
        idle();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
